// File: rtl/alu_simd_result_unpacker_pkg.sv
// Shared constants and lane geometry for the SIMD ALU result unpacker.
// Lane position, width and carry source are all derived from the segment map below.
package alu_simd_pkg;

  localparam logic [1:0] MODE_27X18   = 2'b00;
  localparam logic [1:0] MODE_SUM_9X9 = 2'b01;
  localparam logic [1:0] MODE_SUM_4X4 = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam int SEG0_LSB = 0;
  localparam int SEG0_MSB = 16;
  localparam int SEG1_LSB = 17;
  localparam int SEG1_MSB = 26;
  localparam int SEG2_LSB = 27;
  localparam int SEG2_MSB = 34;
  localparam int SEG3_LSB = 35;
  localparam int TAIL_LSB = 45;
  localparam int SEG3_MSB = TAIL_LSB - 1;
  localparam int TAIL_MSB = 47;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic logic [5:0] seg_lsb(input logic [1:0] k);
    case (k)
      2'd0:    return 6'(SEG0_LSB);
      2'd1:    return 6'(SEG1_LSB);
      2'd2:    return 6'(SEG2_LSB);
      default: return 6'(SEG3_LSB);
    endcase
  endfunction

  function automatic logic [5:0] seg_msb(input logic [1:0] k);
    case (k)
      2'd0:    return 6'(SEG0_MSB);
      2'd1:    return 6'(SEG1_MSB);
      2'd2:    return 6'(SEG2_MSB);
      default: return 6'(SEG3_MSB);
    endcase
  endfunction

  function automatic logic [2:0] lane_count(input logic [1:0] mode);
    case (mode)
      MODE_27X18:   return 3'd1;
      MODE_SUM_9X9: return 3'd2;
      MODE_SUM_4X4: return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  // Segment whose carry pair (and MSB) closes the lane.
  function automatic logic [1:0] lane_top_seg(input logic [1:0] mode, input logic [1:0] idx);
    case (mode)
      MODE_SUM_9X9: return (idx == 2'd0) ? 2'd1 : 2'd3;
      MODE_SUM_4X4: return idx;
      default:      return 2'd3;
    endcase
  endfunction

  function automatic logic [5:0] lane_lsb(input logic [1:0] mode, input logic [1:0] idx);
    case (mode)
      MODE_SUM_9X9: return (idx == 2'd0) ? 6'(SEG0_LSB) : 6'(SEG2_LSB);
      MODE_SUM_4X4: return seg_lsb(idx);
      default:      return 6'(SEG0_LSB);
    endcase
  endfunction

  function automatic logic [5:0] lane_width(input logic [1:0] mode, input logic [1:0] idx);
    case (mode)
      MODE_27X18:   return 6'(TAIL_MSB - SEG0_LSB + 1);
      MODE_SUM_9X9,
      MODE_SUM_4X4: return seg_msb(lane_top_seg(mode, idx)) - lane_lsb(mode, idx) + 6'd1;
      default:      return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_simd_result_unpacker_if.sv
// Packed-word input stream and lane output stream of the SIMD result unpacker.
interface alu_simd_result_unpacker_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_s;
  logic [7:0]  in_carry;
  logic [1:0]  in_use_simd;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [5:0]  out_width;
  logic [1:0]  out_idx;
  logic [1:0]  out_carry;
  logic        out_last;
  logic        err_illegal;

  modport slave (
    input  in_valid, in_s, in_carry, in_use_simd, out_ready,
    output in_ready, out_valid, out_data, out_width, out_idx, out_carry, out_last, err_illegal
  );

  modport master (
    output in_valid, in_s, in_carry, in_use_simd, out_ready,
    input  in_ready, out_valid, out_data, out_width, out_idx, out_carry, out_last, err_illegal
  );
endinterface

// File: rtl/alu_simd_result_unpacker_lane_extract.sv
// Combinational lane selector: slices one lane out of a held ALU word and extends it.
module alu_simd_lane_extract
  import alu_simd_pkg::*;
#(
  parameter bit SIGN_EXTEND = 1'b0
) (
  input  logic [47:0] i_s,
  input  logic [7:0]  i_carry,
  input  logic [1:0]  i_mode,
  input  logic [1:0]  i_idx,
  output logic [47:0] o_data,
  output logic [5:0]  o_width,
  output logic [1:0]  o_carry,
  output logic        o_last
);

  logic [5:0]  w_lsb;
  logic [1:0]  w_top_seg;
  logic [47:0] w_shifted;
  logic [47:0] w_mask;
  logic        w_sign;

  assign w_lsb     = lane_lsb(i_mode, i_idx);
  assign w_top_seg = lane_top_seg(i_mode, i_idx);
  assign o_width   = lane_width(i_mode, i_idx);
  assign w_shifted = i_s >> w_lsb;
  // A 48-bit lane shifts the one out entirely, leaving an all-ones mask.
  assign w_mask    = (48'd1 << o_width) - 48'd1;
  assign w_sign    = SIGN_EXTEND && (o_width != 6'd0) && w_shifted[o_width - 6'd1];

  assign o_data  = w_sign ? (w_shifted | ~w_mask) : (w_shifted & w_mask);
  assign o_carry = i_carry[{w_top_seg, 1'b0} +: 2];
  assign o_last  = ({1'b0, i_idx} == (lane_count(i_mode) - 3'd1));

endmodule

// File: rtl/alu_simd_result_unpacker.sv
// Holds one packed SIMD ALU result and streams its lanes out one per cycle.
// A new word may load on the same edge the previous word's last lane is taken.
module alu_simd_result_unpacker
  import alu_simd_pkg::*;
#(
  parameter bit SIGN_EXTEND = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  alu_simd_result_unpacker_if.slave          bus
);

  state_t      r_state, w_state_next;
  logic [47:0] r_s, w_s_next;
  logic [7:0]  r_carry, w_carry_next;
  logic [1:0]  r_mode, w_mode_next;
  logic [1:0]  r_idx, w_idx_next;
  logic        r_err, w_err_next;

  logic [47:0] w_lane_data;
  logic [5:0]  w_lane_width;
  logic [1:0]  w_lane_carry;
  logic        w_lane_last;
  logic        w_valid, w_lane_done, w_accept, w_legal;

  alu_simd_lane_extract #(.SIGN_EXTEND(SIGN_EXTEND)) u_extract (
    .i_s     (r_s),
    .i_carry (r_carry),
    .i_mode  (r_mode),
    .i_idx   (r_idx),
    .o_data  (w_lane_data),
    .o_width (w_lane_width),
    .o_carry (w_lane_carry),
    .o_last  (w_lane_last)
  );

  assign w_valid     = (r_state == ST_EMIT);
  assign w_lane_done = w_valid && bus.out_ready && w_lane_last;
  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_legal     = (bus.in_use_simd != MODE_ILLEGAL);

  assign bus.in_ready    = (r_state == ST_IDLE) || w_lane_done;
  assign bus.out_valid   = w_valid;
  // Lane fields read as zero whenever nothing is being offered.
  assign bus.out_data    = w_valid ? w_lane_data  : '0;
  assign bus.out_width   = w_valid ? w_lane_width : '0;
  assign bus.out_idx     = w_valid ? r_idx        : '0;
  assign bus.out_carry   = w_valid ? w_lane_carry : '0;
  assign bus.out_last    = w_valid && w_lane_last;
  assign bus.err_illegal = r_err;

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_carry_next = r_carry;
    w_mode_next  = r_mode;
    w_idx_next   = r_idx;
    w_err_next   = w_accept && !w_legal;

    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_legal) w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          if (!w_lane_last)                w_idx_next   = r_idx + 2'd1;
          else if (!(w_accept && w_legal)) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_accept && w_legal) begin
      w_s_next     = bus.in_s;
      w_carry_next = bus.in_carry;
      w_mode_next  = bus.in_use_simd;
      w_idx_next   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_carry <= '0;
      r_mode  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_carry <= w_carry_next;
      r_mode  <= w_mode_next;
      r_idx   <= w_idx_next;
      r_err   <= w_err_next;
    end
  end

endmodule

// File: tb/tb_alu_simd_result_unpacker.sv
// Scoreboard bench for alu_simd_result_unpacker: expected lanes are queued on word
// acceptance and compared as the DUT hands each lane downstream.
module tb_alu_simd_result_unpacker;

  localparam bit SE = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_simd_result_unpacker_if u_if();

  alu_simd_result_unpacker #(.SIGN_EXTEND(SE)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  typedef struct {
    logic [47:0] data;
    logic [5:0]  width;
    logic [1:0]  idx;
    logic [1:0]  carry;
    logic        last;
  } lane_t;

  lane_t sb[$];
  lane_t mon_e;
  int    n_checks = 0;
  int    n_pass = 0;
  int    lanes_seen = 0;
  logic  err_due = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [47:0] ext(input logic [47:0] raw, input int w);
    logic [47:0] r;
    r = raw;
    if (SE && raw[w-1]) for (int b = w; b < 48; b++) r[b] = 1'b1;
    return r;
  endfunction

  function automatic lane_t mk(input logic [47:0] d, input int w, input int i,
                               input logic [1:0] c, input logic l);
    lane_t t;
    t.data  = ext(d, w);
    t.width = 6'(w);
    t.idx   = 2'(i);
    t.carry = c;
    t.last  = l;
    return t;
  endfunction

  task automatic push_word(input logic [47:0] s, input logic [7:0] c, input logic [1:0] m);
    case (m)
      2'b00: sb.push_back(mk(s, 48, 0, c[7:6], 1'b1));
      2'b01: begin
        sb.push_back(mk({21'd0, s[26:0]}, 27, 0, c[3:2], 1'b0));
        sb.push_back(mk({30'd0, s[44:27]}, 18, 1, c[7:6], 1'b1));
      end
      2'b10: begin
        sb.push_back(mk({31'd0, s[16:0]},  17, 0, c[1:0], 1'b0));
        sb.push_back(mk({38'd0, s[26:17]}, 10, 1, c[3:2], 1'b0));
        sb.push_back(mk({40'd0, s[34:27]},  8, 2, c[5:4], 1'b0));
        sb.push_back(mk({38'd0, s[44:35]}, 10, 3, c[7:6], 1'b1));
      end
      default: ;
    endcase
  endtask

  // Monitor: inputs only change just after posedge, so negedge sees settled handshakes.
  always @(negedge clk) begin
    if (reset) begin
      err_due = 1'b0;
    end else begin
      if (err_due || u_if.err_illegal)
        check_val("err_illegal", 64'(u_if.err_illegal), 64'(err_due));
      err_due = u_if.in_valid && u_if.in_ready && (u_if.in_use_simd == 2'b11);
      if (u_if.out_valid && u_if.out_ready) begin
        lanes_seen++;
        check_val("lane_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_val("lane_data",  64'(u_if.out_data),  64'(mon_e.data));
          check_val("lane_width", 64'(u_if.out_width), 64'(mon_e.width));
          check_val("lane_idx",   64'(u_if.out_idx),   64'(mon_e.idx));
          check_val("lane_carry", 64'(u_if.out_carry), 64'(mon_e.carry));
          check_val("lane_last",  64'(u_if.out_last),  64'(mon_e.last));
          $display("lane idx=%0d width=%0d data=%012h carry=%b last=%b",
                   u_if.out_idx, u_if.out_width, u_if.out_data, u_if.out_carry, u_if.out_last);
        end
      end
      if (u_if.in_valid && u_if.in_ready)
        push_word(u_if.in_s, u_if.in_carry, u_if.in_use_simd);
    end
  end

  // Leaves in_valid high after acceptance; the caller drops it or sends the next word.
  task automatic send_word(input logic [47:0] s, input logic [7:0] c, input logic [1:0] m,
                           output int waited);
    u_if.in_valid    = 1'b1;
    u_if.in_s        = s;
    u_if.in_carry    = c;
    u_if.in_use_simd = m;
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      if (u_if.in_ready) break;
      waited++;
    end
    if (waited >= 50) check_val("accept_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || u_if.out_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          total;
    int          n0;
    logic [47:0] rs;
    logic [72:0] snap;

    reset = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.in_s = '0;
    u_if.in_carry = '0;
    u_if.in_use_simd = 2'b00;
    u_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready",  64'(u_if.in_ready),    64'd1);
    check_val("rst_out_valid", 64'(u_if.out_valid),   64'd0);
    check_val("rst_out_data",  64'(u_if.out_data),    64'd0);
    check_val("rst_out_width", 64'(u_if.out_width),   64'd0);
    check_val("rst_out_idx",   64'(u_if.out_idx),     64'd0);
    check_val("rst_out_carry", 64'(u_if.out_carry),   64'd0);
    check_val("rst_out_last",  64'(u_if.out_last),    64'd0);
    check_val("rst_err",       64'(u_if.err_illegal), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Mode 00 single lane
    u_if.out_ready = 1'b1;
    send_word(48'h8000_0000_0001, 8'hC0, 2'b00, w);
    u_if.in_valid = 1'b0;
    check_val("m00_valid_next_cycle", 64'(u_if.out_valid), 64'd1);
    check_val("m00_data",  64'(u_if.out_data),  64'h8000_0000_0001);
    check_val("m00_width", 64'(u_if.out_width), 64'd48);
    check_val("m00_carry", 64'(u_if.out_carry), 64'd3);
    drain();
    check_val("m00_in_ready_after", 64'(u_if.in_ready), 64'd1);

    // Mode 01 with sign extension
    send_word({3'b000, 18'h3FFFF, 27'h4000001}, 8'h4C, 2'b01, w);
    u_if.in_valid = 1'b0;
    check_val("m01_lane0_data", 64'(u_if.out_data), 64'hFFFF_FC00_0001);
    drain();

    // Mode 10 four lanes
    send_word(48'h0000_1234_5678, 8'hE4, 2'b10, w);
    u_if.in_valid = 1'b0;
    drain();

    // Backpressure at idx 1
    send_word(48'hABCD_9876_5432, 8'h1B, 2'b10, w);
    u_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b0;
    @(negedge clk);
    snap = {u_if.out_data, u_if.out_width, u_if.out_idx, u_if.out_carry, u_if.out_last,
            u_if.out_valid, 14'd0};
    check_val("bp_idx", 64'(u_if.out_idx), 64'd1);
    for (int c = 0; c < 3; c++) begin
      check_val("bp_in_ready", 64'(u_if.in_ready), 64'd0);
      @(negedge clk);
      check_val("bp_stable_hi", 64'(snap[72:14] >> 11),
                64'({u_if.out_data, u_if.out_width, u_if.out_idx, u_if.out_carry, u_if.out_last,
                     u_if.out_valid} >> 11));
      check_val("bp_stable_lo", 64'(snap[24:14]),
                64'({u_if.out_width, u_if.out_idx, u_if.out_carry, u_if.out_last, u_if.out_valid}));
    end
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b1;
    drain();

    // Back-to-back mode 00 words
    total = 0;
    n0 = lanes_seen;
    for (int i = 0; i < 5; i++) begin
      send_word(48'h0B2B_0000_0000 | 48'(i * 48'h1_0001_0003), 8'(i << 6), 2'b00, w);
      total += w;
    end
    u_if.in_valid = 1'b0;
    drain();
    check_val("b2b_stall_cycles", 64'(total), 64'd0);
    check_val("b2b_lane_count", 64'(lanes_seen - n0), 64'd5);

    // Illegal mode
    send_word(48'h0000_0000_0123, 8'hFF, 2'b11, w);
    u_if.in_valid = 1'b0;
    check_val("ill_err_pulse", 64'(u_if.err_illegal), 64'd1);
    check_val("ill_no_valid",  64'(u_if.out_valid),   64'd0);
    @(posedge clk);
    #1;
    check_val("ill_err_clear", 64'(u_if.err_illegal), 64'd0);
    check_val("ill_still_idle", 64'(u_if.out_valid), 64'd0);

    // Asynchronous reset during idx 2
    send_word(48'h1357_9BDF_2468, 8'h36, 2'b10, w);
    u_if.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_val("rst_mid_idx", 64'(u_if.out_idx), 64'd2);
    reset = 1'b1;
    #1;
    check_val("rst_mid_valid",    64'(u_if.out_valid), 64'd0);
    check_val("rst_mid_in_ready", 64'(u_if.in_ready),  64'd1);
    check_val("rst_mid_data",     64'(u_if.out_data),  64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_mid_stays_idle", 64'(u_if.out_valid), 64'd0);

    // Random words with random downstream stalls
    for (int i = 0; i < 16; i++) begin
      rs = 48'({$urandom(), $urandom()});
      fork
        begin
          send_word(rs, 8'($urandom()), 2'($urandom_range(0, 3)), w);
          u_if.in_valid = 1'b0;
        end
        begin
          for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            u_if.out_ready = 1'($urandom_range(0, 1));
          end
          u_if.out_ready = 1'b1;
        end
      join
    end
    u_if.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_simd_result_unpacker.md
# alu_simd_result_unpacker

Consumer-side companion to the 48-bit SIMD ALU: it accepts one packed ALU result word (S, per-segment carry-outs and the SIMD mode it was computed under) and emits the individual lane results one per cycle over a valid/ready stream. It sits between the ALU output register and the downstream accumulator/writeback logic, hiding segment boundaries from consumers.

## Interface
Parameters:
- SIGN_EXTEND, 0: 1 = sign-extend each lane to 48 bits; 0 = zero-extend.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  packed result word present.
- in_ready  out  1  unpacker can accept a word this cycle.
- in_s  in  48  ALU result S.
- in_carry  in  8  result_SIMD_carry_out, 2 bits per segment (segment k at [2k+1:2k]).
- in_use_simd  in  2  mode of the word: 00 = 27x18, 01 = sum 9x9, 10 = sum 4x4, 11 = illegal.
- out_valid  out  1  lane result present.
- out_ready  in  1  downstream accepts lane.
- out_data  out  48  lane value, extended per SIGN_EXTEND.
- out_width  out  6  lane width in bits.
- out_idx  out  2  lane index within word.
- out_carry  out  2  carry pair of the lane's top segment.
- out_last  out  1  final lane of the word.
- err_illegal  out  1  one-cycle pulse on acceptance of a mode-11 word.

## Operation
- Segments: seg0 S[16:0], seg1 S[26:17], seg2 S[34:27], seg3 S[44:35], tail S[47:45].
- Mode 00: 1 lane, S[47:0], width 48, carry = in_carry[7:6].
- Mode 01: 2 lanes: lane0 S[26:0] width 27 carry in_carry[3:2]; lane1 S[44:27] width 18 carry in_carry[7:6].
- Mode 10: 4 lanes = seg0..seg3, widths 17,10,8,10, carry = in_carry of that segment.
- Tail bits S[47:45] are ignored in modes 01/10.
- States: IDLE (holding register empty), EMIT (holding word, lane counter idx).
- IDLE: in_ready=1; on in_valid with legal mode, capture s/carry/mode, idx=0, go EMIT. Illegal mode: word consumed, err_illegal=1 next cycle, stay IDLE, no lanes emitted.
- EMIT: out_valid=1; out_* driven from the held word and idx. On out_ready: if not last, idx+1; if last, go IDLE unless a new word is accepted the same cycle.
- Back-to-back: in_ready = IDLE or (EMIT and out_valid and out_ready and out_last); a word accepted in that cycle loads directly into EMIT with idx=0.
- out_data/out_width/out_idx/out_carry/out_last hold stable while out_valid and not out_ready.
- Held word is never modified while in EMIT.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_width=0, out_idx=0, out_carry=0, out_last=0, err_illegal=0; state IDLE.
- Latency: word accepted at edge N → first lane valid after edge N (visible cycle N+1).
- Throughput: one lane per cycle with out_ready held high; mode 10 word occupies 4 cycles, mode 00 sustains one word per cycle.
- Reset asserted mid-word: held word discarded immediately, outputs return to reset values asynchronously.
- err_illegal is registered, high exactly one cycle.

## Structure
- Package alu_simd_pkg: mode constants MODE_27X18=2'b00, MODE_SUM_9X9=2'b01, MODE_SUM_4X4=2'b10; segment LSB/MSB constants (0/16, 17/26, 27/34, 35/44, 45/47); lane-count and lane-width lookup functions.
- Sub-module alu_simd_lane_extract: combinational (held S, carry, mode, idx) → data, width, carry, last; extension done there.

## Test plan
- Mode 00, S=48'h8000_0000_0001, carry=8'hC0, out_ready=1 → one lane, data=48'h8000_0000_0001, width=48, carry=2'b11, last=1, next cycle in_ready=1.
- Mode 01, S[26:0]=27'h4000001, S[44:27]=18'h3FFFF, SIGN_EXTEND=1 → lane0 data=48'hFFFF_FC00_0001 width 27; lane1 data=48'hFFFF_FFFF_FFFF width 18, last=1.
- Mode 10, S=48'h0000_1234_5678, SIGN_EXTEND=0 → 4 lanes widths 17,10,8,10, idx 0..3, values match slices, last only on idx 3.
- Backpressure: mode 10, out_ready low 3 cycles at idx 1 → outputs stable, in_ready=0 throughout; resume completes idx 2,3.
- Back-to-back mode 00 words with out_ready=1 for 5 cycles → 5 lanes on 5 consecutive cycles, no bubbles.
- Mode 11 word → err_illegal one cycle, out_valid stays 0; reset during idx 2 of a mode 10 word → out_valid=0 immediately, in_ready=1.
